mem_port_arbiter: RTL and testbench

Shared single-port memory arbiter for the pipelined RISC-V core. It accepts requests from two requesters, instruction fetch (IF) and data memory (DM), and issues one request at a time to a single unified memory port. It returns the memory read data to whichever requester was granted. It is the 1-to-2 return-path counterpart of the datapath's 2-to-1 source selection: one shared port fans back out to two consumers, with a handshake and a latency counter.

---
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single shared memory port.
// One transaction in flight at a time, round-robin on contention, fixed read latency.
module mem_port_arbiter #(
    parameter int N       = 32,
    parameter int ADDR_W  = 12,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [N-1:0]      if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [N-1:0]      dm_wdata,
    output logic              dm_ready,
    output logic [N-1:0]      dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [N-1:0]      mem_wdata,
    input  logic [N-1:0]      mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    state_t     state;
    state_t     state_next;
    logic [2:0] cnt;
    logic       last_grant;   // 0 = IF served last, 1 = DM served last
    logic       if_elig;
    logic       dm_elig;
    logic       grant_if;
    logic       grant_dm;
    logic       last_beat;

    // A requester whose ready is pulsing this cycle is not eligible, so a
    // req held one cycle past completion cannot re-issue the same access.
    always_comb begin
        // NOTE: every signal gets a value before any branch, so no latch is inferred.
        if_elig   = if_req && !if_ready;
        dm_elig   = dm_req && !dm_ready;
        grant_dm  = (state == IDLE) && dm_elig && (!if_elig || !last_grant);
        grant_if  = (state == IDLE) && if_elig && !grant_dm;
        last_beat = (cnt == 3'd1);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_dm)      state_next = BUSY_DM;
                else if (grant_if) state_next = BUSY_IF;
            end
            BUSY_IF, BUSY_DM: begin
                if (last_beat) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // All outputs are registered; the grant decode above feeds this process.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= 3'd0;
            last_grant <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ready   <= 1'b0;
            dm_ready   <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            mem_en   <= 1'b0;
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        mem_addr   <= dm_addr;
                        mem_we     <= dm_we;
                        mem_wdata  <= dm_wdata;
                        mem_en     <= 1'b1;
                        cnt        <= LAT;
                        last_grant <= 1'b1;
                    end else if (grant_if) begin
                        mem_addr   <= if_addr;
                        mem_we     <= 1'b0;
                        mem_wdata  <= '0;
                        mem_en     <= 1'b1;
                        cnt        <= LAT;
                        last_grant <= 1'b0;
                    end
                end
                BUSY_IF: begin
                    cnt <= cnt - 3'd1;
                    if (last_beat) begin
                        if_rdata <= mem_rdata;
                        if_ready <= 1'b1;
                    end
                end
                BUSY_DM: begin
                    cnt <= cnt - 3'd1;
                    if (last_beat) begin
                        // Writes complete without disturbing the last load value.
                        if (!mem_we) dm_rdata <= mem_rdata;
                        dm_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1 and one with MEM_LAT=3.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- MEM_LAT = 1 instance ----------------
    logic        rst1;
    logic        if_req1, if_ready1, dm_req1, dm_we1, dm_ready1, mem_en1, mem_we1;
    logic [11:0] if_addr1, dm_addr1, mem_addr1;
    logic [31:0] if_rdata1, dm_wdata1, dm_rdata1, mem_wdata1, mem_rdata1;

    // ---------------- MEM_LAT = 3 instance ----------------
    logic        rst3;
    logic        if_req3, if_ready3, dm_req3, dm_we3, dm_ready3, mem_en3, mem_we3;
    logic [11:0] if_addr3, dm_addr3, mem_addr3;
    logic [31:0] if_rdata3, dm_wdata3, dm_rdata3, mem_wdata3, mem_rdata3;

    // Combinational memory contents seen by the latency-1 instance.
    function automatic logic [31:0] model_rd(input logic [11:0] a);
        return (a == 12'h010) ? 32'h0050_0093 : {20'hC0DE0, a};
    endfunction

    assign mem_rdata1 = model_rd(mem_addr1);

    mem_port_arbiter #(.N(32), .ADDR_W(12), .MEM_LAT(1)) u1 (
        .clk(clk), .rst(rst1),
        .if_req(if_req1), .if_addr(if_addr1), .if_ready(if_ready1), .if_rdata(if_rdata1),
        .dm_req(dm_req1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
        .dm_ready(dm_ready1), .dm_rdata(dm_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1)
    );

    mem_port_arbiter #(.N(32), .ADDR_W(12), .MEM_LAT(3)) u3 (
        .clk(clk), .rst(rst3),
        .if_req(if_req3), .if_addr(if_addr3), .if_ready(if_ready3), .if_rdata(if_rdata3),
        .dm_req(dm_req3), .dm_we(dm_we3), .dm_addr(dm_addr3), .dm_wdata(dm_wdata3),
        .dm_ready(dm_ready3), .dm_rdata(dm_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3)
    );

    task automatic test_reset;
        rst1 = 1'b1; rst3 = 1'b1;
        if_req1 = 0; if_addr1 = '0; dm_req1 = 0; dm_we1 = 0; dm_addr1 = '0; dm_wdata1 = '0;
        if_req3 = 0; if_addr3 = '0; dm_req3 = 0; dm_we3 = 0; dm_addr3 = '0; dm_wdata3 = '0;
        mem_rdata3 = 32'hBAD0_BAD0;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_en1, mem_we1, mem_addr1, mem_wdata1, if_ready1, dm_ready1, if_rdata1, dm_rdata1} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_lat1: got en=%b we=%b addr=%h wdata=%h ifr=%b dmr=%b ifd=%h dmd=%h, expected all 0",
                     mem_en1, mem_we1, mem_addr1, mem_wdata1, if_ready1, dm_ready1, if_rdata1, dm_rdata1);
        end
        checks++;
        if ({mem_en3, mem_we3, mem_addr3, mem_wdata3, if_ready3, dm_ready3, if_rdata3, dm_rdata3} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_lat3: got en=%b we=%b addr=%h ifr=%b dmr=%b, expected all 0",
                     mem_en3, mem_we3, mem_addr3, if_ready3, dm_ready3);
        end
        rst1 = 1'b0; rst3 = 1'b0;
        @(negedge clk);
    endtask

    // Both request in the same cycle straight out of reset: DM first, then IF.
    task automatic test_first_contention;
        if_req1 = 1; if_addr1 = 12'h004;
        dm_req1 = 1; dm_we1 = 0; dm_addr1 = 12'h200;
        @(negedge clk);
        checks++;
        if (mem_en1 !== 1'b1 || mem_addr1 !== 12'h200) begin
            errors++;
            $display("FAIL first_grant_dm: got en=%b addr=%h, expected en=1 addr=200", mem_en1, mem_addr1);
        end
        @(negedge clk);
        checks++;
        if (dm_ready1 !== 1'b1 || dm_rdata1 !== 32'hC0DE_0200 || if_ready1 !== 1'b0) begin
            errors++;
            $display("FAIL first_dm_ready: got dmr=%b dmd=%h ifr=%b, expected dmr=1 dmd=c0de0200 ifr=0",
                     dm_ready1, dm_rdata1, if_ready1);
        end
        dm_req1 = 0;
        @(negedge clk);
        checks++;
        if (mem_en1 !== 1'b1 || mem_addr1 !== 12'h004 || mem_we1 !== 1'b0) begin
            errors++;
            $display("FAIL second_grant_if: got en=%b addr=%h we=%b, expected en=1 addr=004 we=0",
                     mem_en1, mem_addr1, mem_we1);
        end
        @(negedge clk);
        checks++;
        if (if_ready1 !== 1'b1 || if_rdata1 !== 32'hC0DE_0004) begin
            errors++;
            $display("FAIL second_if_ready: got ifr=%b ifd=%h, expected ifr=1 ifd=c0de0004", if_ready1, if_rdata1);
        end
        if_req1 = 0;
        @(negedge clk);
    endtask

    task automatic test_write;
        dm_req1 = 1; dm_we1 = 1; dm_addr1 = 12'h100; dm_wdata1 = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (mem_en1 !== 1'b1 || mem_we1 !== 1'b1 || mem_addr1 !== 12'h100 || mem_wdata1 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_issue: got en=%b we=%b addr=%h wdata=%h, expected 1 1 100 deadbeef",
                     mem_en1, mem_we1, mem_addr1, mem_wdata1);
        end
        @(negedge clk);
        checks++;
        if (dm_ready1 !== 1'b1 || dm_rdata1 !== 32'hC0DE_0200) begin
            errors++;
            $display("FAIL write_ready: got dmr=%b dmd=%h, expected dmr=1 dmd=c0de0200 (unchanged)",
                     dm_ready1, dm_rdata1);
        end
        dm_req1 = 0; dm_we1 = 0;
        @(negedge clk);
        checks++;
        if (dm_ready1 !== 1'b0 || mem_en1 !== 1'b0) begin
            errors++;
            $display("FAIL write_pulse_end: got dmr=%b en=%b, expected 0 0", dm_ready1, mem_en1);
        end
    endtask

    task automatic test_fetch;
        if_req1 = 1; if_addr1 = 12'h010;
        @(negedge clk);
        checks++;
        if (mem_en1 !== 1'b1 || mem_addr1 !== 12'h010 || mem_we1 !== 1'b0 || mem_wdata1 !== 32'h0) begin
            errors++;
            $display("FAIL fetch_issue: got en=%b addr=%h we=%b wdata=%h, expected 1 010 0 0",
                     mem_en1, mem_addr1, mem_we1, mem_wdata1);
        end
        @(negedge clk);
        checks++;
        if (if_ready1 !== 1'b1 || if_rdata1 !== 32'h0050_0093 || dm_ready1 !== 1'b0 || mem_en1 !== 1'b0) begin
            errors++;
            $display("FAIL fetch_ready: got ifr=%b ifd=%h dmr=%b en=%b, expected 1 00500093 0 0",
                     if_ready1, if_rdata1, dm_ready1, mem_en1);
        end
        if_req1 = 0;
        @(negedge clk);
        checks++;
        if (if_ready1 !== 1'b0 || mem_en1 !== 1'b0 || mem_addr1 !== 12'h010) begin
            errors++;
            $display("FAIL fetch_after: got ifr=%b en=%b addr=%h, expected 0 0 010", if_ready1, mem_en1, mem_addr1);
        end
    endtask

    // Both requests held continuously; grants must alternate DM, IF, ... every 2 cycles.
    task automatic test_back_to_back;
        int grants = 0;
        int last_cyc = 0;
        int en_repeat = 0;
        int both_ready = 0;
        logic prev_en = 1'b0;
        logic got_dm;
        logic want_dm;
        if_req1 = 1; if_addr1 = 12'h004;
        dm_req1 = 1; dm_we1 = 0; dm_addr1 = 12'h200;
        for (int cyc = 0; cyc < 40 && grants < 6; cyc++) begin
            @(negedge clk);
            if (prev_en && mem_en1) en_repeat++;
            if (if_ready1 && dm_ready1) both_ready++;
            prev_en = mem_en1;
            if (mem_en1) begin
                got_dm  = (mem_addr1 == 12'h200);
                want_dm = (grants % 2 == 0);
                checks++;
                if (got_dm !== want_dm) begin
                    errors++;
                    $display("FAIL b2b_order[%0d]: got dm=%b, expected dm=%b", grants, got_dm, want_dm);
                end
                if (grants > 0) begin
                    checks++;
                    if (cyc - last_cyc != 2) begin
                        errors++;
                        $display("FAIL b2b_spacing[%0d]: got %0d cycles, expected 2", grants, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                grants++;
            end
        end
        checks++;
        if (grants != 6) begin
            errors++;
            $display("FAIL b2b_count: got %0d grants within budget, expected 6", grants);
        end
        checks++;
        if (en_repeat != 0 || both_ready != 0) begin
            errors++;
            $display("FAIL b2b_exclusive: got en_repeat=%0d both_ready=%0d, expected 0 0", en_repeat, both_ready);
        end
        if_req1 = 0; dm_req1 = 0;
        repeat (3) @(negedge clk);
    endtask

    // MEM_LAT=3: only the value on mem_rdata at the third edge after the grant may be captured.
    task automatic test_lat3;
        mem_rdata3 = 32'hBAD0_BAD0;
        if_req3 = 1; if_addr3 = 12'h008;
        @(negedge clk);
        checks++;
        if (mem_en3 !== 1'b1 || mem_addr3 !== 12'h008 || mem_we3 !== 1'b0) begin
            errors++;
            $display("FAIL lat3_issue: got en=%b addr=%h we=%b, expected 1 008 0", mem_en3, mem_addr3, mem_we3);
        end
        @(negedge clk);
        checks++;
        if (if_ready3 !== 1'b0 || mem_en3 !== 1'b0 || if_rdata3 !== 32'h0) begin
            errors++;
            $display("FAIL lat3_edge1: got ifr=%b en=%b ifd=%h, expected 0 0 0", if_ready3, mem_en3, if_rdata3);
        end
        @(negedge clk);
        checks++;
        if (if_ready3 !== 1'b0 || if_rdata3 !== 32'h0) begin
            errors++;
            $display("FAIL lat3_edge2: got ifr=%b ifd=%h, expected 0 0", if_ready3, if_rdata3);
        end
        mem_rdata3 = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if (if_ready3 !== 1'b1 || if_rdata3 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL lat3_edge3: got ifr=%b ifd=%h, expected 1 12345678", if_ready3, if_rdata3);
        end
        if_req3 = 0;
        mem_rdata3 = 32'hFFFF_0000;
        @(negedge clk);
        checks++;
        if (if_ready3 !== 1'b0 || if_rdata3 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL lat3_after: got ifr=%b ifd=%h, expected 0 12345678", if_ready3, if_rdata3);
        end
    endtask

    task automatic test_reset_mid_op;
        int dm_pulses = 0;
        int seen = 0;
        dm_req3 = 1; dm_we3 = 0; dm_addr3 = 12'h200;
        @(negedge clk);
        checks++;
        if (mem_en3 !== 1'b1 || mem_addr3 !== 12'h200) begin
            errors++;
            $display("FAIL midrst_grant: got en=%b addr=%h, expected 1 200", mem_en3, mem_addr3);
        end
        @(posedge clk);
        #1;
        rst3 = 1'b1;
        dm_req3 = 0;
        #1;
        checks++;
        if ({mem_en3, mem_we3, mem_addr3, mem_wdata3, if_ready3, dm_ready3, if_rdata3, dm_rdata3} !== '0) begin
            errors++;
            $display("FAIL midrst_immediate: got addr=%h ifd=%h dmr=%b, expected all 0",
                     mem_addr3, if_rdata3, dm_ready3);
        end
        repeat (4) begin
            @(negedge clk);
            if (dm_ready3) dm_pulses++;
        end
        rst3 = 1'b0;
        @(negedge clk);
        if (dm_ready3) dm_pulses++;
        mem_rdata3 = 32'h0000_1111;
        if_req3 = 1; if_addr3 = 12'h008;
        for (int cyc = 1; cyc <= 10 && seen == 0; cyc++) begin
            @(negedge clk);
            if (dm_ready3) dm_pulses++;
            if (if_ready3) seen = cyc;
        end
        if_req3 = 0;
        checks++;
        if (dm_pulses != 0) begin
            errors++;
            $display("FAIL midrst_no_dm_ready: got %0d pulses, expected 0", dm_pulses);
        end
        checks++;
        if (seen != 4 || if_rdata3 !== 32'h0000_1111) begin
            errors++;
            $display("FAIL midrst_new_fetch: got ready at cycle %0d ifd=%h, expected cycle 4 ifd=00001111",
                     seen, if_rdata3);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_first_contention();
        test_write();
        test_fetch();
        test_back_to_back();
        test_lat3();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
